// File: rtl/bmp_pkg.sv
// Shared constants for the bitmap ROM path.
// Holds the ROM geometry, the read latency, the compositor transparency key,
// the layer index constants, and a small helper for sizing pointer fields.
package bmp_pkg;

  localparam int BMP_AW      = 18;   // ROM address width
  localparam int BMP_DW      = 12;   // ROM data width: 4 bits each of R, G, B
  localparam int BMP_ROM_LAT = 2;    // rom_addr valid -> rom_data valid, in cycles

  // Pixel value treated as "see-through" by the downstream compositor.
  localparam logic [BMP_DW-1:0] TRANSPARENT_KEY = 12'hfff;

  // Which fetcher sits on which arbiter port.
  typedef enum logic [1:0] {
    L_BACK  = 2'd0,
    L_BTN   = 2'd1,
    L_CAR   = 2'd2,
    L_SPARE = 2'd3
  } layer_e;

  // Width of an index into n items; never less than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Ports:
//   cand   - candidate request vector
//   ptr    - index searched first; search continues upward and wraps to 0
//   onehot - one-hot winner (all zero when cand is zero)
//   idx    - winner index (0 when cand is zero)
module rr_pick
  import bmp_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx
);

  // Walk the offsets from farthest to nearest so the candidate closest to
  // ptr (in wrap order) is the last one written and therefore wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[(int'(ptr) + k) % N]) begin
        onehot                         = '0;
        onehot[(int'(ptr) + k) % N]    = 1'b1;
        idx                            = PW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one single-port bitmap ROM between NREQ pixel-layer
// fetchers. Round-robin within a priority class, urgent requests first. Each
// read is returned to its issuer ROM_LAT+1 cycles after the grant, in order.
// Ports:
//   clk, clr        - system clock / synchronous active-high reset
//   req, urgent     - per-requester request and priority class
//   addr            - flattened addresses, requester i at [i*AW +: AW]
//   gnt             - combinational one-hot grant
//   rom_en,rom_addr - registered ROM read port
//   rom_data        - ROM read data
//   rvalid, rdata   - one-hot return strobe and returned data
module rom_port_arbiter
  import bmp_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = BMP_AW,
  parameter int DW      = BMP_DW,
  parameter int ROM_LAT = BMP_ROM_LAT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   urgent,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic              rom_en,
  output logic [AW-1:0]     rom_addr,
  input  logic [DW-1:0]     rom_data,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata
);

  localparam int PW = ptr_width(NREQ);

  logic [NREQ-1:0]           urgent_req;
  logic [NREQ-1:0]           cand;
  logic [NREQ-1:0]           pick_onehot;
  logic [PW-1:0]             pick_idx;
  logic                      grant;

  logic [PW-1:0]             ptr_reg;
  logic                      rom_en_reg;
  logic [AW-1:0]             rom_addr_reg;
  // Stage 0 is loaded on the grant edge; stage ROM_LAT lines up with rom_data.
  logic [ROM_LAT:0][NREQ-1:0] tag_reg;

  // Urgent requesters mask out everyone else whenever at least one is present.
  assign urgent_req = req & urgent;
  assign cand       = (urgent_req != '0) ? urgent_req : req;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .cand   (cand),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign gnt   = clr ? '0 : pick_onehot;
  assign grant = |gnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_reg      <= '0;
      rom_en_reg   <= 1'b0;
      rom_addr_reg <= '0;
      tag_reg      <= '0;
    end else begin
      rom_en_reg <= grant;
      tag_reg[0] <= gnt;
      for (int s = 1; s <= ROM_LAT; s++) begin
        tag_reg[s] <= tag_reg[s-1];
      end
      if (grant) begin
        rom_addr_reg <= addr[int'(pick_idx)*AW +: AW];
        ptr_reg      <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end

  assign rom_en   = rom_en_reg;
  assign rom_addr = rom_addr_reg;
  assign rvalid   = tag_reg[ROM_LAT];
  assign rdata    = rom_data;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Testbench for rom_port_arbiter: directed scenarios followed by a random
// phase, all checked against a transaction-level reference model.
module tb_rom_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 18;
  localparam int DW   = 12;
  localparam int LAT  = 2;

  logic               clk = 1'b0;
  logic               clr;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    urgent;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic               rom_en;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

  logic [AW-1:0]      a [NREQ];
  logic [DW-1:0]      rom_s1;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) addr[i*AW +: AW] = a[i];
  end

  // ROM model: data = addr[11:0], two cycles after the address is presented.
  always @(posedge clk) begin
    rom_s1   <= rom_addr[DW-1:0];
    rom_data <= rom_s1;
  end

  rom_port_arbiter #(
    .NREQ    (NREQ),
    .AW      (AW),
    .DW      (DW),
    .ROM_LAT (LAT)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .urgent   (urgent),
    .addr     (addr),
    .gnt      (gnt),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rvalid   (rvalid),
    .rdata    (rdata)
  );

  // Reference model state
  int            vectors    = 0;
  int            miscompares = 0;
  int            cyc        = 0;
  int            m_ptr      = 0;
  int            m_last_w   = -1;
  logic          m_en       = 1'b0;
  logic [AW-1:0] m_addr     = '0;
  logic [NREQ-1:0] exp_rv [16];
  logic [DW-1:0]   exp_rd [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Spec rule: urgent class wins if present, then first set bit from ptr upward.
  function automatic int winner(input logic [NREQ-1:0] r, input logic [NREQ-1:0] u, input int p);
    logic [NREQ-1:0] c;
    c = ((r & u) != 0) ? (r & u) : r;
    for (int k = 0; k < NREQ; k++) begin
      if (c[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Check one cycle at the falling edge, then advance the model across the
  // next rising edge and return 1 time unit after it.
  task automatic step();
    int w;
    int s;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    w  = clr ? -1 : winner(req, urgent, m_ptr);
    eg = (w < 0) ? '0 : NREQ'(1 << w);
    $display("cyc %0d clr=%b req=%b urg=%b gnt=%b rom_en=%b rom_addr=%h rvalid=%b rdata=%h",
             cyc, clr, req, urgent, gnt, rom_en, rom_addr, rvalid, rdata);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("rom_en", 32'(rom_en), 32'(m_en));
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    s = cyc % 16;
    chk("rvalid", 32'(rvalid), 32'(exp_rv[s]));
    if (exp_rv[s] != '0) chk("rdata", 32'(rdata), 32'(exp_rd[s]));
    exp_rv[s] = '0;
    if (clr) begin
      m_ptr  = 0;
      m_en   = 1'b0;
      m_addr = '0;
      for (int i = 0; i < 16; i++) exp_rv[i] = '0;
    end else begin
      m_en = (w >= 0);
      if (w >= 0) begin
        m_ptr  = (w + 1) % NREQ;
        m_addr = a[w];
        exp_rv[(cyc + LAT + 1) % 16] = eg;
        exp_rd[(cyc + LAT + 1) % 16] = a[w][DW-1:0];
      end
    end
    m_last_w = w;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      exp_rv[i] = '0;
      exp_rd[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) a[i] = AW'(i);
    clr    = 1'b1;
    req    = 4'b1111;
    urgent = 4'b0000;
    @(posedge clk);
    #1;

    // 1. Reset held with all requests up, then first grant goes to requester 0.
    repeat (3) step();
    clr = 1'b0;
    step();
    req = 4'b0000;
    repeat (3) step();

    // 2. Single read by requester 2.
    a[2] = 18'h00100;
    req  = 4'b0100;
    step();
    req  = 4'b0000;
    repeat (3) step();

    // 3. Sustained round-robin from a fresh pointer.
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < NREQ; i++) a[i] = AW'(i + 1);
    req = 4'b1111;
    repeat (5) step();
    req = 4'b0000;
    repeat (3) step();

    // 4. Urgent override, then resume of normal rotation.
    req    = 4'b1111;
    urgent = 4'b0010;
    repeat (5) step();
    urgent = 4'b0000;
    repeat (2) step();
    req = 4'b0000;
    step();

    // 5. Wrap from requester 3 back to 0.
    req = 4'b1001;
    repeat (2) step();
    req = 4'b0000;
    repeat (3) step();

    // 6. Reset while two reads are in flight.
    req = 4'b1111;
    repeat (2) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    req = 4'b0000;
    repeat (5) step();

    // Random phase: requesters hold req/addr until granted.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (i == m_last_w) begin
          req[i] = $urandom_range(0, 1) == 1;
          a[i]   = AW'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            a[i]   = AW'($urandom);
          end
        end
      end
      urgent = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
      clr    = ($urandom_range(0, 49) == 0);
      step();
    end
    clr = 1'b0;
    req = '0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
